// File: rtl/quad_gen.sv
// rtl/quad_gen.sv - quadrature encoder emulator: commanded steps/period to A/B edges
//
// Build option: define QUAD_GEN_INDEX_EN to enable the once-per-revolution index output.
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   cmd_valid       command offered; taken when cmd_valid & cmd_ready
//   cmd_ready       generator idle
//   cmd_steps       signed edge count (>0 forward, <0 reverse)
//   cmd_period      clocks between edges (0 behaves as 1)
//   abort           end the running command at the next clock
//   quadA, quadB    quadrature channels (flop outputs)
//   index           high while position is on a revolution boundary (optional)
//   busy            command in progress
//   done            one-cycle completion strobe
//   position        emitted edge count, wraps modulo 2^POS_WIDTH
module quad_gen #(
    parameter int POS_WIDTH      = 24,
    parameter int PERIOD_WIDTH   = 16,
    parameter int COUNTS_PER_REV = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic signed [POS_WIDTH-1:0]    cmd_steps,
    input  logic        [PERIOD_WIDTH-1:0] cmd_period,
    input  logic                           abort,
    output logic                           quadA,
    output logic                           quadB,
    output logic                           index,
    output logic                           busy,
    output logic                           done,
    output logic        [POS_WIDTH-1:0]    position
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [POS_WIDTH-1:0]    remaining;
    logic [PERIOD_WIDTH-1:0] period;
    logic [PERIOD_WIDTH-1:0] tick;
    logic                    dir;
    logic                    zero_cmd;

    logic                    accept;
    logic                    running;
    logic [POS_WIDTH-1:0]    steps_mag;
    logic [PERIOD_WIDTH-1:0] period_eff;
    logic                    toggle_a;

    assign accept     = (state == S_IDLE) && cmd_valid;
    // Edges are only produced while work remains and no abort is pending;
    // abort therefore suppresses an edge that falls on the same clock.
    assign running    = (state == S_RUN) && !abort && (remaining != '0);
    // Two's complement magnitude; the most negative value maps to 2^(W-1),
    // which still fits the unsigned remaining counter.
    assign steps_mag  = cmd_steps[POS_WIDTH-1] ? (~cmd_steps + 1'b1) : cmd_steps;
    assign period_eff = (cmd_period == '0) ? PERIOD_WIDTH'(1) : cmd_period;
    // Forward walks 00->10->11->01: toggle A when A==B, else B. Reverse is the mirror.
    assign toggle_a   = (quadA ~^ quadB) ^ dir;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A zero-step command spends one quiet cycle in RUN
    // (remaining==0) so that done lands one cycle after acceptance.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_next = S_RUN;
            S_RUN:   if (abort || (remaining == '0)) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state == S_DONE) || ((state == S_RUN) && !zero_cmd);
        done      = (state == S_DONE);
    end

    // Command latch, edge timer and quadrature/position datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            period    <= PERIOD_WIDTH'(1);
            tick      <= '0;
            dir       <= 1'b0;
            zero_cmd  <= 1'b0;
            quadA     <= 1'b0;
            quadB     <= 1'b0;
            position  <= '0;
        end else if (accept) begin
            remaining <= steps_mag;
            dir       <= cmd_steps[POS_WIDTH-1];
            period    <= period_eff;
            tick      <= period_eff - 1'b1;
            zero_cmd  <= (cmd_steps == '0);
        end else if (running) begin
            if (tick == '0) begin
                tick      <= period - 1'b1;
                remaining <= remaining - 1'b1;
                if (toggle_a) begin
                    quadA <= ~quadA;
                end else begin
                    quadB <= ~quadB;
                end
                position  <= dir ? (position - 1'b1) : (position + 1'b1);
            end else begin
                tick <= tick - 1'b1;
            end
        end
    end

`ifdef QUAD_GEN_INDEX_EN
    localparam logic [POS_WIDTH-1:0] REV_MASK = POS_WIDTH'(COUNTS_PER_REV - 1);
    assign index = ((position & REV_MASK) == '0);
`else
    assign index = 1'b0;
`endif

endmodule

// File: tb/tb_quad_gen.sv
// tb/tb_quad_gen.sv - table-driven self-checking bench for quad_gen
module tb_quad_gen;

    localparam int PW  = 24;
    localparam int QW  = 16;
    localparam int CPR = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic signed [PW-1:0] cmd_steps = '0;
    logic        [QW-1:0] cmd_period = '0;
    logic                 abort = 1'b0;
    logic                 quadA, quadB, index, busy, done;
    logic        [PW-1:0] position;

    always #5 clk = ~clk;

    quad_gen #(.POS_WIDTH(PW), .PERIOD_WIDTH(QW), .COUNTS_PER_REV(CPR)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
        .quadA(quadA), .quadB(quadB), .index(index), .busy(busy), .done(done),
        .position(position)
    );

    typedef struct {
        int          steps;
        int          period;
        int          abort_at;   // clock (after accept) at which abort is sampled; 0 = none
        bit          noise;      // hold cmd_valid with junk while busy
        logic [23:0] exp_pos;
        logic [1:0]  exp_ab;     // {A,B}
        int          exp_done;   // clock (after accept) at which done is seen
    } vec_t;

    vec_t        vecs[10];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [23:0] m_pos = '0;
    int          m_ph  = 0;

    function automatic logic [1:0] ph_ab(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic exp_index(input logic [23:0] p);
`ifdef QUAD_GEN_INDEX_EN
        return (p[1:0] == 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle-exact check of one command; expected values come from the edge
    // schedule (edge k at accept+k*P, done one clock after the last edge).
    task automatic run_cmd(input vec_t v);
        int          p;
        bit          dir;
        longint      n, d, e;
        int          seen;
        int          ph;
        logic [23:0] pos;
        @(negedge clk);
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_steps  = 24'(v.steps);
        cmd_period = 16'(v.period);
        @(posedge clk);
        p   = (v.period == 0) ? 1 : v.period;
        dir = (v.steps < 0);
        n   = dir ? -longint'(v.steps) : longint'(v.steps);
        d   = n * p + 1;
        if (v.abort_at > 0 && v.abort_at < d) d = v.abort_at;
        seen = -1;
        e    = 0;
        for (longint c = 0; c <= d + 1; c++) begin
            @(negedge clk);
            if (done && seen < 0) seen = int'(c);
            e = c / p;
            if ((d - 1) / p < e) e = (d - 1) / p;
            if (n < e) e = n;
            ph  = dir ? (m_ph - int'(e)) : (m_ph + int'(e));
            pos = dir ? (m_pos - 24'(e)) : (m_pos + 24'(e));
            check($sformatf("cycle%0d_ab_pos_busy_done_ready_idx", c),
                  {quadA, quadB, position, busy, done, cmd_ready, index},
                  {ph_ab(ph), pos, (c < d) ? (n != 0) : (c == d), c == d, c == d + 1, exp_index(pos)});
            cmd_valid = v.noise && (c < d + 1);
            cmd_steps = v.noise ? 24'sd7 : cmd_steps;
            abort     = (v.abort_at > 0) && (c + 1 == v.abort_at);
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
        m_pos = dir ? (m_pos - 24'(e)) : (m_pos + 24'(e));
        m_ph  = (dir ? (m_ph - int'(e)) : (m_ph + int'(e))) & 3;
        check("done_cycle", seen, v.exp_done);
        check("final_pos", position, v.exp_pos);
        check("final_ab", {quadA, quadB}, v.exp_ab);
    endtask

    initial begin
        vecs[0] = '{4,         3, 0,  1'b0, 24'h000004, 2'b00, 13};
        vecs[1] = '{-6,        1, 0,  1'b0, 24'hFFFFFE, 2'b11, 7};
        vecs[2] = '{0,         7, 0,  1'b0, 24'hFFFFFE, 2'b11, 1};
        vecs[3] = '{100,       5, 13, 1'b0, 24'h000000, 2'b00, 13};
        vecs[4] = '{3,         0, 0,  1'b0, 24'h000003, 2'b01, 4};
        vecs[5] = '{5,         2, 0,  1'b1, 24'h000008, 2'b00, 11};
        vecs[6] = '{-3,        2, 4,  1'b0, 24'h000007, 2'b01, 4};
        vecs[7] = '{-8388608,  1, 3,  1'b0, 24'h000005, 2'b10, 3};
        vecs[8] = '{-7,        1, 0,  1'b0, 24'hFFFFFE, 2'b11, 8};
        vecs[9] = '{3,         1, 0,  1'b0, 24'h000001, 2'b10, 4};

        #12;
        check("reset_state", {quadA, quadB, position, busy, done, cmd_ready, index},
              {2'b00, 24'h0, 1'b0, 1'b0, 1'b1, exp_index(24'h0)});
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_cmd(vecs[i]);

        // Reset in the middle of a long command drops everything at once.
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_steps  = 24'sd50;
        cmd_period = 16'd10;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (24) @(posedge clk);
        check("midrun_pos_before_reset", position, m_pos + 24'd2);
        #2 reset = 1'b1;
        #1 check("async_reset_midrun", {quadA, quadB, position, busy, done, cmd_ready},
                 {2'b00, 24'h0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        reset = 1'b0;
        m_pos = '0;
        m_ph  = 0;

        // abort while idle does nothing
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check("abort_idle_ignored", {position, busy, cmd_ready}, {24'h0, 1'b0, 1'b1});

        run_cmd('{1, 1, 0, 1'b0, 24'h000001, 2'b10, 2});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
